// File: rtl/sort_merge_serializer.sv
// Completes a 4-element sort of pair-sorted blocks, buffers sorted blocks in a FIFO and
// serializes them one element per cycle on a val/rdy stream.
module sort_merge_serializer #(
  parameter int unsigned nbits = 8,
  parameter int unsigned depth = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4*nbits-1:0] in_,
  input  logic               in_val,
  output logic               in_rdy,
  output logic [nbits-1:0]   out,
  output logic               out_val,
  input  logic               out_rdy,
  output logic               out_last,
  output logic               ovf
);

  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] DepthC = (AW + 1)'(depth);

  typedef logic [nbits-1:0] elem_t;
  typedef elem_t [3:0]      blk_t;

  blk_t        in_blk, s2_d, s3_d;
  blk_t        s2_q, s3_q, ser_blk_q;
  logic        s2_val_q, s3_val_q, ser_val_q;
  logic [1:0]  idx_q;
  logic [AW:0] occ_q, wr_ptr_q, rd_ptr_q;
  logic        ovf_q;
  blk_t        fifo_q [depth];

  logic accept, hs, last_hs, fifo_empty, load;

  assign in_blk     = in_;
  assign in_rdy     = reset && (occ_q < DepthC);
  assign accept     = in_val && in_rdy;
  assign hs         = ser_val_q && out_rdy;
  assign last_hs    = hs && (idx_q == 2'd3);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign load       = (!ser_val_q || last_hs) && !fifo_empty;

  // Compare-swap networks: lower value to lower index, ties keep order.
  always_comb begin
    s2_d    = in_blk;
    s2_d[0] = (in_blk[0] <= in_blk[2]) ? in_blk[0] : in_blk[2];
    s2_d[2] = (in_blk[0] <= in_blk[2]) ? in_blk[2] : in_blk[0];
    s2_d[1] = (in_blk[1] <= in_blk[3]) ? in_blk[1] : in_blk[3];
    s2_d[3] = (in_blk[1] <= in_blk[3]) ? in_blk[3] : in_blk[1];
    s3_d    = s2_q;
    s3_d[1] = (s2_q[1] <= s2_q[2]) ? s2_q[1] : s2_q[2];
    s3_d[2] = (s2_q[1] <= s2_q[2]) ? s2_q[2] : s2_q[1];
  end

  always_ff @(posedge clk) begin
    if (s3_val_q) fifo_q[wr_ptr_q[AW-1:0]] <= s3_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_val_q  <= 1'b0;
      s3_val_q  <= 1'b0;
      s2_q      <= '0;
      s3_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ser_val_q <= 1'b0;
      ser_blk_q <= '0;
      idx_q     <= 2'd0;
      occ_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      s2_val_q <= accept;
      if (accept) s2_q <= s2_d;
      s3_val_q <= s2_val_q;
      if (s2_val_q) s3_q <= s3_d;
      if (s3_val_q) wr_ptr_q <= wr_ptr_q + 1'b1;

      if (load) begin
        ser_blk_q <= fifo_q[rd_ptr_q[AW-1:0]];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        idx_q     <= 2'd0;
        ser_val_q <= 1'b1;
      end else if (last_hs) begin
        ser_val_q <= 1'b0;
        idx_q     <= 2'd0;
      end else if (hs) begin
        idx_q <= idx_q + 2'd1;
      end

      if (accept && !last_hs)      occ_q <= occ_q + 1'b1;
      else if (!accept && last_hs) occ_q <= occ_q - 1'b1;

      if (in_val && !in_rdy) ovf_q <= 1'b1;
    end
  end

  assign out_val  = ser_val_q;
  assign out      = ser_val_q ? ser_blk_q[idx_q] : '0;
  assign out_last = ser_val_q && (idx_q == 2'd3);
  assign ovf      = ovf_q;

endmodule

// File: doc/sort_merge_serializer.md
Name: sort_merge_serializer

Overview:
- Downstream neighbour of the flat 4-element pairwise sort stage. That stage delivers 4 x nbits elements with pairs (0,1) and (2,3) already ascending.
- This block completes the 4-element sort with two more pipelined compare-swap stages, buffers whole sorted blocks and emits them one element per cycle on a val/rdy stream.
- It supplies in_rdy back to the producer so the block rate matches the element rate.

Parameters:
- nbits, 8, element width in bits (unsigned).
- depth, 4, maximum blocks in flight (pipeline + block FIFO + serializer); power of two, >= 2.

Ports:
- clk  input  1  clock; all state on posedge.
- reset  input  1  synchronous, active-low: 0 = reset, sampled on posedge clk.
- in_  input  4 x nbits  block; pairs (0,1) and (2,3) pre-sorted ascending.
- in_val  input  1  block valid.
- in_rdy  output  1  block can be accepted this cycle.
- out  output  nbits  current serialized element.
- out_val  output  1  out holds a valid element.
- out_rdy  input  1  consumer accepts out this cycle.
- out_last  output  1  out is element 3 of its block.
- ovf  output  1  sticky: a block was presented while in_rdy was 0.

Behaviour:
- Reset (reset==0 at posedge) clears everything:
  - S2/S3 valid bits, FIFO pointers, serializer state and occupancy counter occ all go to 0.
  - out=0, out_val=0, out_last=0, ovf=0.
  - in_rdy is 0 while reset is low and 1 in the first cycle after release.
  - Reset mid-stream discards all in-flight blocks, including a partially emitted one.
- Accept: a block is taken when in_val && in_rdy.
- Flow control:
  - in_rdy = (occ < depth).
  - occ increments on accept and decrements on the handshake of an out_last element. Both in the same cycle leave occ unchanged.
  - Because occ never exceeds depth, the FIFO cannot overflow and the pipeline never stalls.
- Overflow: if in_val && !in_rdy, the block is dropped and ovf is set to 1. ovf holds until reset.
- Stage S2 (registered on accept): compare-swap (0,2) and (1,3). The lower value goes to the lower index; unsigned compare, a <= b keeps order on ties.
- Stage S3 (registered one cycle later): compare-swap (1,2), same rule.
- Block FIFO:
  - depth entries of 4 x nbits.
  - Written the cycle after S3 is valid.
  - Read by the serializer.
  - The FIFO pointers wrap modulo depth.
- Serializer:
  - Holds one block and a 2-bit index idx.
  - out = element[idx], out_last = (idx==3), out_val = 1 while a block is loaded.
  - On out_val && out_rdy: idx increments. When idx==3, the block is released.
  - Load occurs when (serializer empty) or (last handshake this cycle), and the FIFO is non-empty. The FIFO head is popped and idx=0.
  - Back-to-back blocks therefore have no bubble.
  - While out_val && !out_rdy, out, out_last and idx hold stable.
- Latency: a block accepted in cycle 0 reaches S2 in cycle 1, S3 in cycle 2 and the FIFO in cycle 3. Element 0 appears with out_val=1 in cycle 4, given an empty serializer.
- Throughput: at most one block per 4 cycles with out_rdy held at 1. in_rdy falls once depth blocks are outstanding.
- Input contract: output is sorted ascending only when the input pairs are pre-sorted. There is no check; unsorted pairs give a defined but unspecified permutation.

Test Plan:
- Single block: in_={3,7,1,9} (index 0..3) accepted in cycle 0, out_rdy=1 → out=1,3,7,9 in cycles 4-7; out_last=1 only in cycle 7; out_val=0 in cycle 8.
- Ties: in_={5,5,5,5} → four outputs of 5. in_={2,8,2,8} → 2,2,8,8.
- Backpressure:
  - Apply out_rdy=0 for cycles 4-9 on the single-block case → out=1, out_val=1 held stable through cycle 9.
  - Release → 3,7,9 in cycles 11-13.
- Full / overflow:
  - depth=4, out_rdy=0, in_val=1 every cycle → in_rdy=1 for cycles 0-3 and 0 from cycle 4.
  - Block presented in cycle 4 is dropped and ovf=1 from cycle 5.
  - After one full block drains, in_rdy returns to 1.
- Streaming: 8 blocks, each offered as soon as in_rdy allows, out_rdy=1 → 32 consecutive out_val=1 cycles with no bubble, each block sorted, out_last every 4th element, occ wrapping the FIFO twice.
- Reset mid-operation:
  - Assert reset=0 in cycle 6 of the single-block case → from cycle 7 out_val=0, out=0, ovf=0.
  - After release, in_rdy=1 and a new block {0,255,0,255} emits 0,0,255,255.
